if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 18 +
 rtl/if_fetch_if.sv | 10 +
 rtl/if_id_reg.sv | 35 +++
 rtl/if_fetch.sv | 74 +++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, encodings and reset defaults for the fetch stage
package if_fetch_pkg;
  localparam int ADDR_W = 16;
  localparam int INST_W = 16;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;
  localparam logic [INST_W-1:0] NOP_INST_DEF = 16'h0800;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;
  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_word_t;
  // A branch seen in the advancing cycle beats an older pending redirect.
  function automatic addr_t next_fetch_pc(addr_t pc, logic br, addr_t br_addr, logic pend, addr_t redir);
    return br ? br_addr : pend ? redir : pc + addr_t'(1);
  endfunction
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory read bus between fetch (master) and memory (slave)
interface if_fetch_if;
  import if_fetch_pkg::*;
  logic imem_req;
  addr_t imem_addr;
  logic imem_ack;
  inst_t imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID output register with hold on stall, load or NOP bubble otherwise
module if_id_reg
  import if_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEF,
  parameter inst_t NOP_INST = NOP_INST_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_stall,
  input  logic  i_load,
  input  addr_t i_pc,
  input  inst_t i_inst,
  output addr_t o_pc,
  output inst_t o_inst,
  output logic  o_valid
);
  addr_t r_pc;
  inst_t r_inst;
  logic r_valid;
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_pc <= RESET_PC;
      r_inst <= NOP_INST;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      r_pc <= i_load ? i_pc : r_pc;
      r_inst <= i_load ? i_inst : NOP_INST;
      r_valid <= i_load;
    end
  end
  assign o_pc = r_pc;
  assign o_inst = r_inst;
  assign o_valid = r_valid;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch with one-entry stall buffer and deferred branch redirect
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEF,
  parameter inst_t NOP_INST = NOP_INST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          branch_flag_i,
  input  addr_t         branch_addr_i,
  if_fetch_if.master    imem,
  output addr_t         pc_o,
  output inst_t         inst_o,
  output logic          inst_valid_o,
  output logic          fetch_busy_o
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t r_state;
  addr_t r_fetch_pc;
  addr_t r_redir_addr;
  logic r_redir_pend;
  fetch_word_t r_buf;
  logic w_req;
  logic w_adv;
  logic w_load;
  fetch_word_t w_word;
  // Request is gated by rst so a reset drops it in the same cycle.
  assign w_req = r_state == FETCH && rst != RST_ENABLE;
  assign w_adv = w_req && imem.imem_ack;
  assign w_load = r_state == HOLD || w_adv;
  assign w_word = r_state == HOLD ? r_buf : {r_fetch_pc, imem.imem_rdata};
  assign imem.imem_req = w_req;
  assign imem.imem_addr = r_fetch_pc;
  assign fetch_busy_o = w_req && !imem.imem_ack;
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_redir_addr <= RESET_PC;
      r_buf <= '0;
    end else begin
      if (w_adv) begin
        r_fetch_pc <= next_fetch_pc(r_fetch_pc, branch_flag_i, branch_addr_i, r_redir_pend, r_redir_addr);
        r_redir_pend <= 1'b0;
      end else if (branch_flag_i) begin
        r_redir_pend <= 1'b1;
        r_redir_addr <= branch_addr_i;
      end
      if (w_adv && stall_i) begin
        r_buf <= w_word;
        r_state <= HOLD;
      end else if (r_state == HOLD && !stall_i) begin
        r_state <= FETCH;
      end
    end
  end
  if_id_reg #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk(clk),
    .rst(rst),
    .i_stall(stall_i),
    .i_load(w_load),
    .i_pc(w_word.pc),
    .i_inst(w_word.inst),
    .o_pc(pc_o),
    .o_inst(inst_o),
    .o_valid(inst_valid_o)
  );
endmodule
